// File: rtl/reu_dma_engine.sv
// REU DMA sequencer: owns the C64 bus during a transfer and walks the
// stash/fetch/swap/verify byte sequences, pulsing address/length advances back to the register block.
module reu_dma_engine #(
   parameter int SETUP_CYCLES = 1,
   parameter bit VERIFY_STOP  = 1'b1
) (
   input  logic       PHI2,
   input  logic       Reset,
   input  logic       Execute,
   input  logic       FF00Decode,
   input  logic       FF00Wr,
   input  logic [1:0] XferType,
   input  logic       Length1,
   input  logic       BA,
   input  logic [7:0] C64DIn,
   input  logic [7:0] RAMDIn,
   output logic       nDMA,
   output logic       C64RW,
   output logic       C64WE,
   output logic [7:0] C64DOut,
   output logic       RAMRD,
   output logic       RAMWR,
   output logic [7:0] RAMDOut,
   output logic       NextCA,
   output logic       NextREUA,
   output logic       XferEnd,
   output logic       VerifyErr,
   output logic [3:0] DbgState
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_ARM   = 4'd1,
      S_SETUP = 4'd2,
      S_C64RD = 4'd3,
      S_RAMRD = 4'd4,
      S_RAMWR = 4'd5,
      S_C64WR = 4'd6,
      S_VCMP  = 4'd7,
      S_DONE  = 4'd8
   } state_t;

   localparam logic [1:0] X_STASH = 2'b00;
   localparam logic [1:0] X_FETCH = 2'b01;
   localparam logic [1:0] X_SWAP  = 2'b10;
   localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] setup_cnt_q, setup_cnt_d;
   logic [7:0] data_a_q, data_a_d;
   logic [7:0] data_b_q, data_b_d;
   logic       byte_done;
   state_t     first_st;

   assign first_st = (XferType == X_FETCH) ? S_RAMRD : S_C64RD;
   assign DbgState = state_q;

   always_ff @(negedge PHI2) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         setup_cnt_q <= 2'd0;
         data_a_q    <= 8'd0;
         data_b_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         setup_cnt_q <= setup_cnt_d;
         data_a_q    <= data_a_d;
         data_b_q    <= data_b_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      setup_cnt_d = 2'd0;
      data_a_d    = data_a_q;
      data_b_d    = data_b_q;
      byte_done   = 1'b0;
      nDMA        = 1'b1;
      C64RW       = 1'b1;
      C64WE       = 1'b0;
      C64DOut     = 8'd0;
      RAMRD       = 1'b0;
      RAMWR       = 1'b0;
      RAMDOut     = 8'd0;
      NextCA      = 1'b0;
      NextREUA    = 1'b0;
      XferEnd     = 1'b0;
      VerifyErr   = 1'b0;
      case (state_q)
         S_IDLE: if (Execute) state_d = FF00Decode ? S_ARM : S_SETUP;
         S_ARM: begin
            if (!Execute)    state_d = S_IDLE;
            else if (FF00Wr) state_d = S_SETUP;
         end
         S_SETUP: begin
            nDMA        = 1'b0;
            setup_cnt_d = setup_cnt_q;
            // Only cycles with the bus available count toward the setup delay.
            if (BA) begin
               if (setup_cnt_q == SETUP_LAST) state_d = first_st;
               else                           setup_cnt_d = setup_cnt_q + 2'd1;
            end
         end
         S_C64RD: begin
            nDMA = 1'b0;
            if (BA) begin
               data_a_d = C64DIn;
               case (XferType)
                  X_STASH: state_d = S_RAMWR;
                  X_SWAP:  state_d = S_RAMRD;
                  default: state_d = S_VCMP;
               endcase
            end
         end
         S_RAMRD: begin
            nDMA  = 1'b0;
            RAMRD = 1'b1;
            if (XferType == X_SWAP) begin
               data_b_d = RAMDIn;
               state_d  = S_RAMWR;
            end else begin
               data_a_d = RAMDIn;
               state_d  = S_C64WR;
            end
         end
         S_RAMWR: begin
            nDMA    = 1'b0;
            RAMWR   = 1'b1;
            RAMDOut = data_a_q;
            if (XferType == X_SWAP) state_d = S_C64WR;
            else                    byte_done = 1'b1;
         end
         S_C64WR: begin
            nDMA  = 1'b0;
            C64RW = 1'b0;
            if (BA) begin
               C64WE     = 1'b1;
               C64DOut   = (XferType == X_SWAP) ? data_b_q : data_a_q;
               byte_done = 1'b1;
            end
         end
         S_VCMP: begin
            nDMA  = 1'b0;
            RAMRD = 1'b1;
            if (RAMDIn != data_a_q) begin
               VerifyErr = 1'b1;
               if (VERIFY_STOP) begin
                  XferEnd = Length1;
                  state_d = S_DONE;
               end else begin
                  byte_done = 1'b1;
               end
            end else begin
               byte_done = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Last state of a byte: either advance addresses and loop, or finish.
      if (byte_done) begin
         if (Length1) begin
            XferEnd = 1'b1;
            state_d = S_DONE;
         end else begin
            NextCA   = 1'b1;
            NextREUA = 1'b1;
            state_d  = first_st;
         end
      end
   end

endmodule

// File: tb/tb_reu_dma_engine.sv
// Bench for reu_dma_engine: emulates the register block's length countdown and
// scoreboards every RAM/C64 write against the data it fed in.
module tb_reu_dma_engine;

   localparam int SC = 1;

   logic       PHI2 = 1'b0;
   logic       Reset, Execute, FF00Decode, FF00Wr, Length1, BA;
   logic [1:0] XferType;
   logic [7:0] C64DIn, RAMDIn;
   logic       nDMA, C64RW, C64WE, RAMRD, RAMWR, NextCA, NextREUA, XferEnd, VerifyErr;
   logic [7:0] C64DOut, RAMDOut;
   logic [3:0] DbgState;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_ram_q[$];
   logic [7:0] exp_c64_q[$];
   logic [7:0] c64_tab[8];
   logic [7:0] ram_tab[8];
   int n_len, bytes_done;
   int cnt_next, cnt_end, cnt_err, cnt_err_end, cnt_ndma, cnt_ramwr, cnt_c64we;
   bit stall_en;

   reu_dma_engine #(.SETUP_CYCLES(SC), .VERIFY_STOP(1'b1)) dut (
      .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .FF00Decode(FF00Decode),
      .FF00Wr(FF00Wr), .XferType(XferType), .Length1(Length1), .BA(BA),
      .C64DIn(C64DIn), .RAMDIn(RAMDIn), .nDMA(nDMA), .C64RW(C64RW),
      .C64WE(C64WE), .C64DOut(C64DOut), .RAMRD(RAMRD), .RAMWR(RAMWR),
      .RAMDOut(RAMDOut), .NextCA(NextCA), .NextREUA(NextREUA),
      .XferEnd(XferEnd), .VerifyErr(VerifyErr), .DbgState(DbgState)
   );

   always #5 PHI2 = ~PHI2;

   task automatic clear_counts();
      exp_ram_q.delete();
      exp_c64_q.delete();
      bytes_done  = 0;
      cnt_next    = 0;
      cnt_end     = 0;
      cnt_err     = 0;
      cnt_err_end = 0;
      cnt_ndma    = 0;
      cnt_ramwr   = 0;
      cnt_c64we   = 0;
      stall_en    = 1'b0;
   endtask

   // One PHI2 cycle: drive inputs on the rising edge, observe mid-cycle.
   task automatic step();
      logic [7:0] exp;
      @(posedge PHI2);
      Length1 = ((n_len - bytes_done) == 1);
      C64DIn  = c64_tab[bytes_done % 8];
      RAMDIn  = ram_tab[bytes_done % 8];
      BA      = !(stall_en && cnt_ndma >= SC && cnt_ndma < SC + 3);
      #1;
      if (RAMWR) begin
         cnt_ramwr++;
         total++;
         if (exp_ram_q.size() == 0) begin
            bad++;
            $display("FAIL ramwr_unexpected: RAMDOut=%02h, none expected", RAMDOut);
         end else begin
            exp = exp_ram_q.pop_front();
            if (RAMDOut !== exp) begin
               bad++;
               $display("FAIL ramdout: got %02h expected %02h", RAMDOut, exp);
            end
         end
      end
      if (C64WE) begin
         cnt_c64we++;
         total++;
         if (exp_c64_q.size() == 0) begin
            bad++;
            $display("FAIL c64we_unexpected: C64DOut=%02h, none expected", C64DOut);
         end else begin
            exp = exp_c64_q.pop_front();
            if (C64DOut !== exp || C64RW !== 1'b0) begin
               bad++;
               $display("FAIL c64dout: got %02h rw=%b expected %02h rw=0", C64DOut, C64RW, exp);
            end
         end
      end
      if (NextCA || NextREUA) begin
         total++;
         if (NextCA !== NextREUA) begin
            bad++;
            $display("FAIL next_pair: NextCA=%b NextREUA=%b expected equal", NextCA, NextREUA);
         end
      end
      if (!BA && (C64WE || NextCA || XferEnd || VerifyErr)) begin
         total++;
         bad++;
         $display("FAIL stall_pulse: C64WE=%b NextCA=%b XferEnd=%b with BA=0", C64WE, NextCA, XferEnd);
      end
      if (NextCA)               cnt_next++;
      if (XferEnd)              cnt_end++;
      if (VerifyErr)            cnt_err++;
      if (VerifyErr && XferEnd) cnt_err_end++;
      if (nDMA === 1'b0)        cnt_ndma++;
      if (NextCA)               bytes_done++;
   endtask

   // Run until the DONE cycle (nDMA back high), then release Execute and expect IDLE.
   task automatic run_xfer(input int max_cycles);
      bit seen_low, done;
      seen_low = 1'b0;
      done     = 1'b0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         step();
         if (nDMA === 1'b0) seen_low = 1'b1;
         else if (seen_low) done = 1'b1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL xfer_timeout: no DONE within %0d cycles", max_cycles);
      end
      Execute    = 1'b0;
      FF00Decode = 1'b0;
      step();
      total++;
      if (DbgState !== 4'd0 || nDMA !== 1'b1) begin
         bad++;
         $display("FAIL back_to_idle: state=%0d nDMA=%b expected 0/1", DbgState, nDMA);
      end
   endtask

   task automatic check_counts(input string name, input int e_next, input int e_end,
                               input int e_err, input int e_ndma);
      total++;
      if (cnt_next !== e_next || cnt_end !== e_end || cnt_err !== e_err || cnt_ndma !== e_ndma) begin
         bad++;
         $display("FAIL %s_counts: next=%0d end=%0d err=%0d ndma=%0d expected %0d/%0d/%0d/%0d",
                  name, cnt_next, cnt_end, cnt_err, cnt_ndma, e_next, e_end, e_err, e_ndma);
      end
      total++;
      if (exp_ram_q.size() != 0 || exp_c64_q.size() != 0) begin
         bad++;
         $display("FAIL %s_leftover: ram_q=%0d c64_q=%0d expected 0/0", name,
                  exp_ram_q.size(), exp_c64_q.size());
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      step();
      total++;
      if (nDMA !== 1'b1 || C64RW !== 1'b1 || DbgState !== 4'd0) begin
         bad++;
         $display("FAIL reset_ctrl: nDMA=%b C64RW=%b state=%0d expected 1/1/0", nDMA, C64RW, DbgState);
      end
      total++;
      if ({C64WE, RAMRD, RAMWR, NextCA, NextREUA, XferEnd, VerifyErr} !== 7'd0 ||
          C64DOut !== 8'd0 || RAMDOut !== 8'd0) begin
         bad++;
         $display("FAIL reset_outs: strobes=%b c64=%02h ram=%02h expected zero",
                  {C64WE, RAMRD, RAMWR, NextCA, NextREUA, XferEnd, VerifyErr}, C64DOut, RAMDOut);
      end
      Reset = 1'b0;
      step();
   endtask

   task automatic test_stash();
      clear_counts();
      n_len = 3;
      c64_tab[0] = 8'h11; c64_tab[1] = 8'h22; c64_tab[2] = 8'h33;
      for (int i = 0; i < 3; i++) exp_ram_q.push_back(c64_tab[i]);
      XferType = 2'b00;
      Execute  = 1'b1;
      run_xfer(40);
      check_counts("stash", 2, 1, 0, SC + 6);
      total++;
      if (cnt_ramwr !== 3) begin
         bad++;
         $display("FAIL stash_ramwr: got %0d expected 3", cnt_ramwr);
      end
   endtask

   task automatic test_fetch();
      clear_counts();
      n_len = 1;
      ram_tab[0] = 8'hA5;
      exp_c64_q.push_back(8'hA5);
      XferType = 2'b01;
      Execute  = 1'b1;
      run_xfer(20);
      check_counts("fetch", 0, 1, 0, SC + 2);
      total++;
      if (cnt_c64we !== 1) begin
         bad++;
         $display("FAIL fetch_c64we: got %0d expected 1", cnt_c64we);
      end
   endtask

   task automatic test_swap();
      clear_counts();
      n_len = 1;
      c64_tab[0] = 8'h5A;
      ram_tab[0] = 8'hC3;
      exp_ram_q.push_back(8'h5A);
      exp_c64_q.push_back(8'hC3);
      XferType = 2'b10;
      Execute  = 1'b1;
      run_xfer(20);
      check_counts("swap", 0, 1, 0, SC + 4);
   endtask

   task automatic test_verify_stop();
      clear_counts();
      n_len = 3;
      c64_tab[0] = 8'h10; c64_tab[1] = 8'h20; c64_tab[2] = 8'h30;
      ram_tab[0] = 8'h10; ram_tab[1] = 8'h21; ram_tab[2] = 8'h30;
      XferType = 2'b11;
      Execute  = 1'b1;
      run_xfer(30);
      check_counts("verify_stop", 1, 0, 1, SC + 4);
   endtask

   task automatic test_verify_last();
      clear_counts();
      n_len = 2;
      c64_tab[0] = 8'h44; c64_tab[1] = 8'h55;
      ram_tab[0] = 8'h44; ram_tab[1] = 8'h56;
      XferType = 2'b11;
      Execute  = 1'b1;
      run_xfer(30);
      check_counts("verify_last", 1, 1, 1, SC + 4);
      total++;
      if (cnt_err_end !== 1) begin
         bad++;
         $display("FAIL verify_last_together: got %0d expected 1", cnt_err_end);
      end
   endtask

   task automatic test_ff00_stall();
      clear_counts();
      n_len = 2;
      c64_tab[0] = 8'h77; c64_tab[1] = 8'h88;
      exp_ram_q.push_back(8'h77);
      exp_ram_q.push_back(8'h88);
      XferType   = 2'b00;
      FF00Decode = 1'b1;
      Execute    = 1'b1;
      for (int i = 0; i < 4; i++) step();
      total++;
      if (cnt_ndma !== 0 || nDMA !== 1'b1) begin
         bad++;
         $display("FAIL ff00_hold: ndma_cycles=%0d nDMA=%b expected 0/1", cnt_ndma, nDMA);
      end
      stall_en = 1'b1;
      FF00Wr   = 1'b1;
      step();
      FF00Wr   = 1'b0;
      run_xfer(40);
      check_counts("ff00_stall", 1, 1, 0, SC + 4 + 3);
   endtask

   task automatic test_random_stash();
      clear_counts();
      n_len = 4;
      for (int i = 0; i < 4; i++) begin
         c64_tab[i] = 8'($urandom_range(0, 255));
         exp_ram_q.push_back(c64_tab[i]);
      end
      XferType = 2'b00;
      Execute  = 1'b1;
      run_xfer(40);
      check_counts("random_stash", 3, 1, 0, SC + 8);
   endtask

   task automatic test_reset_mid_swap();
      bit hit;
      clear_counts();
      hit = 1'b0;
      n_len = 1;
      c64_tab[0] = 8'h5A;
      ram_tab[0] = 8'hC3;
      exp_ram_q.push_back(8'h5A);
      XferType = 2'b10;
      Execute  = 1'b1;
      for (int i = 0; i < 12 && !hit; i++) begin
         step();
         if (RAMWR === 1'b1) hit = 1'b1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL mid_swap_reach: RAMWR not seen within 12 cycles");
      end
      Reset   = 1'b1;
      Execute = 1'b0;
      step();
      total++;
      if (nDMA !== 1'b1 || RAMWR !== 1'b0 || XferEnd !== 1'b0 || DbgState !== 4'd0) begin
         bad++;
         $display("FAIL mid_swap_reset: nDMA=%b RAMWR=%b XferEnd=%b state=%0d expected 1/0/0/0",
                  nDMA, RAMWR, XferEnd, DbgState);
      end
      Reset = 1'b0;
      step();
      step();
      total++;
      if (cnt_end !== 0 || DbgState !== 4'd0) begin
         bad++;
         $display("FAIL mid_swap_after: xferend=%0d state=%0d expected 0/0", cnt_end, DbgState);
      end
   endtask

   initial begin
      Reset      = 1'b1;
      Execute    = 1'b0;
      FF00Decode = 1'b0;
      FF00Wr     = 1'b0;
      XferType   = 2'b00;
      Length1    = 1'b0;
      BA         = 1'b1;
      C64DIn     = 8'd0;
      RAMDIn     = 8'd0;
      n_len      = 1;
      for (int i = 0; i < 8; i++) begin
         c64_tab[i] = 8'd0;
         ram_tab[i] = 8'd0;
      end
      clear_counts();
      test_reset();
      test_stash();
      test_fetch();
      test_swap();
      test_verify_stop();
      test_verify_last();
      test_ff00_stall();
      test_random_stash();
      test_reset_mid_swap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
